// File: rtl/sram_req_arbiter_pkg.sv
// Shared encodings for the SRAM request arbiter: requester IDs, FSM states,
// the fixed fetch access size and a bundle type for one muxed memory request.
package sram_req_arbiter_pkg;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_HOLD_I = 2'd1;
  localparam logic [1:0] ARB_HOLD_D = 2'd2;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sram_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered transactions.
// Full is taken from the registered count only, so a pop in the same cycle
// never makes room for a push in that cycle.
module sram_id_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  // Store the ID of each accepted transaction at the write pointer.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_din;
  end

  // Advance pointers and track occupancy; push+pop leaves the count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between fetch (inst) and load/store (data).
// Data has fixed priority in IDLE; a grant that is not accepted at once is
// held in HOLD_I/HOLD_D until addr_ok. Responses are routed in order using
// the ID FIFO. Both the address and response paths are purely combinational.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  logic [1:0] r_state;
  logic [1:0] w_nextState;
  logic       r_respErr;
  logic       w_grant;
  logic       w_owner;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_head;
  mem_req_t   w_memReq;

  // Pick the owner: fixed data priority in IDLE when a slot is free, otherwise the held owner.
  always_comb begin
    w_grant = 1'b0;
    w_owner = ARB_ID_INST;
    case (r_state)
      ARB_IDLE: begin
        if (!w_full) begin
          if (data_req) begin
            w_grant = 1'b1;
            w_owner = ARB_ID_DATA;
          end else if (inst_req) begin
            w_grant = 1'b1;
            w_owner = ARB_ID_INST;
          end
        end
      end
      ARB_HOLD_I: begin
        w_grant = 1'b1;
        w_owner = ARB_ID_INST;
      end
      ARB_HOLD_D: begin
        w_grant = 1'b1;
        w_owner = ARB_ID_DATA;
      end
      default: begin
        w_grant = 1'b0;
        w_owner = ARB_ID_INST;
      end
    endcase
  end

  // Mux the owner's request fields onto the shared port; fetches are fixed word reads.
  always_comb begin
    w_memReq = '0;
    if (w_grant) begin
      if (w_owner == ARB_ID_DATA) begin
        w_memReq.wr    = data_wr;
        w_memReq.size  = data_size;
        w_memReq.addr  = data_addr;
        w_memReq.wstrb = data_wstrb;
        w_memReq.wdata = data_wdata;
      end else begin
        w_memReq.size  = SIZE_WORD;
        w_memReq.addr  = inst_addr;
      end
    end
  end

  assign mem_req   = w_grant & ~reset;
  assign mem_wr    = w_memReq.wr;
  assign mem_size  = w_memReq.size;
  assign mem_addr  = w_memReq.addr;
  assign mem_wstrb = w_memReq.wstrb;
  assign mem_wdata = w_memReq.wdata;

  assign w_push       = mem_req & mem_addr_ok;
  assign inst_addr_ok = w_push & (w_owner == ARB_ID_INST);
  assign data_addr_ok = w_push & (w_owner == ARB_ID_DATA);

  assign w_pop        = mem_data_ok & ~w_empty & ~reset;
  assign inst_data_ok = w_pop & (w_head == ARB_ID_INST);
  assign data_data_ok = w_pop & (w_head == ARB_ID_DATA);
  assign rdata        = mem_rdata;
  assign resp_err     = r_respErr;

  // Hold an unaccepted grant until addr_ok, then return to IDLE for re-arbitration.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (mem_req && !mem_addr_ok)
          w_nextState = (w_owner == ARB_ID_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
      end
      ARB_HOLD_I, ARB_HOLD_D: begin
        if (mem_addr_ok) w_nextState = ARB_IDLE;
      end
      default: w_nextState = ARB_IDLE;
    endcase
  end

  // State register; reset drops any held grant.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_nextState;
  end

  // A response with nothing outstanding is a protocol error that stays set until reset.
  always_ff @(posedge clk) begin
    if (reset)                       r_respErr <= 1'b0;
    else if (mem_data_ok && w_empty) r_respErr <= 1'b1;
  end

  sram_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (1)
  ) u_idFifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_owner),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter. The bench plays the memory side,
// records the expected requester and read data of every transaction it
// accepts in a scoreboard queue, and checks routing when it responds.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        resp_err;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbQueue [$];
  int   compareCount  = 0;
  int   mismatchCount = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .rdata        (rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .resp_err     (resp_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'b10;
    data_addr   = '0;
    data_wstrb  = '0;
    data_wdata  = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  // Drive one response for the oldest expected transaction and check its routing.
  task automatic applyStimulus(input string tag, input bit checkNoGrant);
    exp_t e;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 32'd0, 32'd1);
      return;
    end
    e = sbQueue.pop_front();
    mem_data_ok = 1'b1;
    mem_rdata   = e.rdata;
    #1;
    checkOutput({tag, "_instDataOk"}, 32'(inst_data_ok), 32'(e.id == 1'b0));
    checkOutput({tag, "_dataDataOk"}, 32'(data_data_ok), 32'(e.id == 1'b1));
    checkOutput({tag, "_rdata"}, rdata, e.rdata);
    if (checkNoGrant) checkOutput({tag, "_noSameCycleGrant"}, 32'(mem_req), 32'd0);
    tick();
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst_memReq", 32'(mem_req), 32'd0);
    checkOutput("rst_respErr", 32'(resp_err), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("postRst_memReq", 32'(mem_req), 32'd0);
    checkOutput("postRst_addrOk", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    checkOutput("postRst_dataOk", 32'({inst_data_ok, data_data_ok}), 32'd0);

    // Scenario 1: single fetch, response three cycles later
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0000;
    mem_addr_ok = 1'b1;
    #1;
    checkOutput("t1_memReq", 32'(mem_req), 32'd1);
    checkOutput("t1_memAddr", mem_addr, 32'h1C00_0000);
    checkOutput("t1_memSize", 32'(mem_size), 32'd2);
    checkOutput("t1_instAddrOk", 32'(inst_addr_ok), 32'd1);
    checkOutput("t1_dataAddrOk", 32'(data_addr_ok), 32'd0);
    sbQueue.push_back('{1'b0, 32'h0280_0C0C});
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b0;
    #1;
    checkOutput("t1_instAddrOkOnce", 32'(inst_addr_ok), 32'd0);
    tick();
    tick();
    applyStimulus("t1_resp", 1'b0);

    // Scenario 2: simultaneous requests, data store wins first
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0004;
    data_req    = 1'b1;
    data_wr     = 1'b1;
    data_addr   = 32'h0000_01C0;
    data_wstrb  = 4'b0011;
    data_wdata  = 32'hDEAD_BEEF;
    mem_addr_ok = 1'b1;
    #1;
    checkOutput("t2_memWr", 32'(mem_wr), 32'd1);
    checkOutput("t2_memAddr", mem_addr, 32'h0000_01C0);
    checkOutput("t2_memWstrb", 32'(mem_wstrb), 32'h3);
    checkOutput("t2_memWdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("t2_dataAddrOk", 32'(data_addr_ok), 32'd1);
    checkOutput("t2_instLoses", 32'(inst_addr_ok), 32'd0);
    sbQueue.push_back('{1'b1, 32'h1111_1111});
    tick();
    data_req = 1'b0;
    data_wr  = 1'b0;
    #1;
    checkOutput("t2_instAddr", mem_addr, 32'h1C00_0004);
    checkOutput("t2_instWr", 32'(mem_wr), 32'd0);
    checkOutput("t2_instWstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("t2_instAddrOk", 32'(inst_addr_ok), 32'd1);
    sbQueue.push_back('{1'b0, 32'h2222_2222});
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b0;
    applyStimulus("t2_resp0", 1'b0);
    applyStimulus("t2_resp1", 1'b0);

    // Scenario 3: held fetch grant is not pre-empted by a later data request
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0100;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        data_req  = 1'b1;
        data_addr = 32'h0000_0300;
      end
      #1;
      checkOutput($sformatf("t3_holdAddr%0d", c), mem_addr, 32'h1C00_0100);
      checkOutput($sformatf("t3_noAccept%0d", c), 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      tick();
    end
    mem_addr_ok = 1'b1;
    #1;
    checkOutput("t3_instAddrOk", 32'(inst_addr_ok), 32'd1);
    checkOutput("t3_dataWaits", 32'(data_addr_ok), 32'd0);
    sbQueue.push_back('{1'b0, 32'h3333_0001});
    tick();
    inst_req = 1'b0;
    #1;
    checkOutput("t3_dataAddr", mem_addr, 32'h0000_0300);
    checkOutput("t3_dataAddrOk", 32'(data_addr_ok), 32'd1);
    sbQueue.push_back('{1'b1, 32'h3333_0002});
    tick();
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    applyStimulus("t3_resp0", 1'b0);
    applyStimulus("t3_resp1", 1'b0);

    // Scenario 4: FIFO full blocks a third request until the cycle after a pop
    data_req    = 1'b1;
    data_addr   = 32'h0000_0400;
    mem_addr_ok = 1'b1;
    #1;
    checkOutput("t4_load0Ok", 32'(data_addr_ok), 32'd1);
    sbQueue.push_back('{1'b1, 32'h4444_0000});
    tick();
    data_addr = 32'h0000_0404;
    #1;
    checkOutput("t4_load1Ok", 32'(data_addr_ok), 32'd1);
    sbQueue.push_back('{1'b1, 32'h4444_0001});
    tick();
    data_req  = 1'b0;
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0200;
    #1;
    checkOutput("t4_fullNoReq", 32'(mem_req), 32'd0);
    checkOutput("t4_fullNoAccept", 32'(inst_addr_ok), 32'd0);
    tick();
    applyStimulus("t4_resp0", 1'b1);
    #1;
    checkOutput("t4_grantAfterPop", 32'(inst_addr_ok), 32'd1);
    sbQueue.push_back('{1'b0, 32'h4444_0002});
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b0;
    applyStimulus("t4_resp1", 1'b0);
    applyStimulus("t4_resp2", 1'b0);
    checkOutput("t4_noErr", 32'(resp_err), 32'd0);

    // Scenario 5: stray response sets the sticky error; reset clears it
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h5555_5555;
    #1;
    checkOutput("t5_strayNoDataOk", 32'({inst_data_ok, data_data_ok}), 32'd0);
    tick();
    mem_data_ok = 1'b0;
    #1;
    checkOutput("t5_errSet", 32'(resp_err), 32'd1);
    tick();
    tick();
    checkOutput("t5_errSticky", 32'(resp_err), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("t5_errCleared", 32'(resp_err), 32'd0);

    // Scenario 6: steady push+pop at one outstanding over ten transactions
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0600;
    mem_addr_ok = 1'b1;
    #1;
    checkOutput("t6_prime", 32'(inst_addr_ok), 32'd1);
    sbQueue.push_back('{1'b0, 32'h6600_0000});
    tick();
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      logic isData;
      isData      = (i % 2) == 0;
      e           = sbQueue.pop_front();
      data_req    = isData;
      data_addr   = 32'h0000_0600 + 32'(i * 4);
      inst_req    = ~isData;
      inst_addr   = 32'h1C00_0604 + 32'(i * 4);
      mem_data_ok = 1'b1;
      mem_rdata   = e.rdata;
      #1;
      checkOutput($sformatf("t6_addrOk%0d", i), 32'({inst_addr_ok, data_addr_ok}), isData ? 32'd1 : 32'd2);
      checkOutput($sformatf("t6_route%0d", i), 32'({inst_data_ok, data_data_ok}), e.id ? 32'd1 : 32'd2);
      checkOutput($sformatf("t6_rdata%0d", i), rdata, e.rdata);
      sbQueue.push_back('{isData, 32'h6600_0001 + 32'(i)});
      tick();
    end
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    applyStimulus("t6_last", 1'b0);
    checkOutput("t6_noErr", 32'(resp_err), 32'd0);
    checkOutput("t6_sbDrained", 32'(sbQueue.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
